// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-port asynchronous SRAM controller, one transfer per request
module sram_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                Mem_CE,
    output logic                Mem_OE,
    output logic                Mem_WE,
    output logic [DATA_W/8-1:0] Mem_BE,
    output logic [ADDR_W-1:0]   ADDR,
    inout  wire  [DATA_W-1:0]   Data
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   be_mask;
    logic                busy;
    logic                drive;

    // Expand the latched byte enables into a bit mask for read data.
    always_comb begin
        be_mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            be_mask[i*8 +: 8] = {8{be_q[i]}};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        ready_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = SETUP;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = 4'(WAIT_CYCLES);
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = Data & be_mask;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // ready_q keeps req_ready low while reset is held even though state is IDLE.
    assign busy      = (state_q == SETUP) || (state_q == ACCESS);
    assign drive     = we_q && (state_q != IDLE);
    assign req_ready = ready_q && (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rdata_q;
    assign ADDR      = addr_q;
    assign Mem_CE    = !busy;
    assign Mem_OE    = !(busy && !we_q);
    assign Mem_WE    = !(we_q && (state_q == ACCESS));
    assign Mem_BE    = busy ? ~be_q : {BE_W{1'b1}};
    assign Data      = drive ? wdata_q : {DATA_W{1'bz}};

endmodule
